// File: rtl/cpu_defs.sv
// Shared CPU type definitions: virtual address type and branch-predictor
// table entry layout.
package cpu_defs;

  typedef logic [31:0] virt_t;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // Tag field sized for the smallest legal table (4 entries); larger tables
  // store a zero-extended tag.
  localparam int unsigned BP_TAG_MAX_W = 28;

  typedef struct packed {
    logic                    valid;
    logic [BP_TAG_MAX_W-1:0] tag;
    logic [29:0]             target;
    bp_ctr_t                 ctr;
  } bp_entry_t;

endpackage

// File: rtl/bp_sat_counter2.sv
// Next-state function of a 2-bit saturating direction counter.
module bp_sat_counter2
  import cpu_defs::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, trained by resolved outcomes from EXE.
module branch_predictor
  import cpu_defs::*;
#(
  parameter  int ENTRIES = 64,
  localparam int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fs_pc,
  output logic        predict_is_taken,
  output logic [31:0] predict_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_is_branch,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  output logic [31:0] perf_lookups,
  output logic [31:0] perf_mispredicts
);

  localparam int TAG_W = 30 - INDEX_W;

  bp_entry_t btb_q [ENTRIES];
  logic      armed_q;

  logic [INDEX_W-1:0]      lk_idx, upd_idx;
  logic [BP_TAG_MAX_W-1:0] lk_tag, upd_tag;
  bp_entry_t               lk_entry, upd_entry;
  logic                    lk_hit, upd_hit;
  logic [1:0]              ctr_next;
  logic                    unused_low_bits;

  assign unused_low_bits = ^{fs_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  assign lk_idx  = fs_pc[INDEX_W+1:2];
  assign upd_idx = upd_pc[INDEX_W+1:2];
  assign lk_tag  = BP_TAG_MAX_W'(fs_pc[31:INDEX_W+2]);
  assign upd_tag = BP_TAG_MAX_W'(upd_pc[31:INDEX_W+2]);

  assign lk_entry  = btb_q[lk_idx];
  assign upd_entry = btb_q[upd_idx];
  assign lk_hit    = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

  bp_sat_counter2 u_ctr (
    .ctr      (upd_entry.ctr),
    .taken    (upd_taken),
    .ctr_next (ctr_next)
  );

  // armed_q stays low for the first edge after reset release, so an update
  // presented on that edge is dropped and predictions stay quiet that cycle.
  always_comb begin
    predict_is_taken = armed_q && lk_hit && (lk_entry.ctr inside {WT, ST});
    predict_target   = predict_is_taken ? {lk_entry.target, 2'b00} : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) btb_q[i] <= '0;
      armed_q          <= 1'b0;
      perf_lookups     <= '0;
      perf_mispredicts <= '0;
    end else begin
      armed_q      <= 1'b1;
      perf_lookups <= perf_lookups + 32'd1;
      if (armed_q && upd_valid) begin
        if (upd_mispredict) perf_mispredicts <= perf_mispredicts + 32'd1;
        if (upd_hit) begin
          if (!upd_is_branch) begin
            btb_q[upd_idx].valid <= 1'b0;
          end else begin
            btb_q[upd_idx].ctr <= bp_ctr_t'(ctr_next);
            if (upd_taken) btb_q[upd_idx].target <= upd_target[31:2];
          end
        end else if (upd_is_branch && upd_taken) begin
          btb_q[upd_idx] <= '{valid: 1'b1, tag: upd_tag,
                              target: upd_target[31:2], ctr: WT};
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (ENTRIES=64).
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fs_pc;
  logic        predict_is_taken;
  logic [31:0] predict_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_branch;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic [31:0] perf_lookups;
  logic [31:0] perf_mispredicts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(64)) dut (
    .clk              (clk),
    .reset            (reset),
    .fs_pc            (fs_pc),
    .predict_is_taken (predict_is_taken),
    .predict_target   (predict_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_is_branch    (upd_is_branch),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .perf_lookups     (perf_lookups),
    .perf_mispredicts (perf_mispredicts)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_pred(input string name, input logic exp_t, input logic [31:0] exp_tgt);
    chk({name, ".taken"}, {31'd0, predict_is_taken}, {31'd0, exp_t});
    chk({name, ".target"}, predict_target, exp_tgt);
  endtask

  task automatic drive_upd(input logic v, input logic [31:0] pc, input logic br,
                           input logic tk, input logic [31:0] tgt, input logic mp);
    upd_valid      = v;
    upd_pc         = pc;
    upd_is_branch  = br;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_mispredict = mp;
  endtask

  // Each row: lookup and update presented together; the lookup is checked
  // before the edge, so it sees the state left by the previous rows.
  typedef struct {
    logic [31:0] fs_pc;
    logic        uv;
    logic [31:0] upc;
    logic        br;
    logic        tk;
    logic [31:0] tgt;
    logic        mp;
    logic        exp_t;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[$];

  localparam logic [31:0] PA = 32'h8000_0010;
  localparam logic [31:0] PB = 32'h8000_0110;
  localparam logic [31:0] PC = 32'h8000_0020;
  localparam logic [31:0] PD = 32'h8000_00FC;
  localparam logic [31:0] PE = 32'h0000_00FC;
  localparam logic [31:0] PX = 32'h8000_0040;

  initial begin
    logic [31:0] p0;

    vecs.push_back('{PA, 1, PA, 1, 1, 32'h8000_0080, 1, 0, 0});            // allocate, same-cycle lookup
    vecs.push_back('{PA, 0, 0,  0, 0, 0,             0, 1, 32'h8000_0080}); // ctr WT
    vecs.push_back('{PB, 0, 0,  0, 0, 0,             0, 0, 0});             // alias, tag differs
    vecs.push_back('{PA, 1, PA, 1, 0, 0,             1, 1, 32'h8000_0080}); // -> WNT
    vecs.push_back('{PA, 1, PA, 1, 0, 0,             0, 0, 0});             // -> SNT
    vecs.push_back('{PA, 1, PA, 1, 0, 0,             0, 0, 0});             // stays SNT
    vecs.push_back('{PA, 1, PA, 1, 1, 32'h8000_0100, 0, 0, 0});             // -> WNT, new target
    vecs.push_back('{PA, 1, PA, 1, 1, 32'h8000_0100, 0, 0, 0});             // -> WT
    vecs.push_back('{PA, 1, PA, 1, 1, 32'h8000_0100, 0, 1, 32'h8000_0100}); // -> ST
    vecs.push_back('{PA, 1, PA, 1, 1, 32'h8000_0100, 0, 1, 32'h8000_0100}); // stays ST
    vecs.push_back('{PA, 1, PA, 1, 0, 0,             1, 1, 32'h8000_0100}); // -> WT
    vecs.push_back('{PA, 0, 0,  0, 0, 0,             0, 1, 32'h8000_0100}); // still taken
    vecs.push_back('{PA, 0, PA, 0, 0, 0,             1, 1, 32'h8000_0100}); // upd_valid=0 ignored
    vecs.push_back('{PA, 1, PB, 1, 1, 32'h8000_0200, 1, 1, 32'h8000_0100}); // B evicts A
    vecs.push_back('{PA, 0, 0,  0, 0, 0,             0, 0, 0});
    vecs.push_back('{PB, 1, PB, 0, 0, 0,             0, 1, 32'h8000_0200}); // non-branch hit
    vecs.push_back('{PB, 0, 0,  0, 0, 0,             0, 0, 0});             // invalidated
    vecs.push_back('{PA, 1, PA, 1, 1, 32'h8000_0080, 0, 0, 0});
    vecs.push_back('{PA, 1, PA, 0, 0, 0,             0, 1, 32'h8000_0080});
    vecs.push_back('{PA, 0, 0,  0, 0, 0,             0, 0, 0});
    vecs.push_back('{PC, 1, PC, 1, 0, 0,             1, 0, 0});             // miss, not taken
    vecs.push_back('{PC, 0, 0,  0, 0, 0,             0, 0, 0});
    vecs.push_back('{PD, 1, PD, 1, 1, 32'h0000_0004, 0, 0, 0});             // top index
    vecs.push_back('{PD, 0, 0,  0, 0, 0,             0, 1, 32'h0000_0004});
    vecs.push_back('{PE, 0, 0,  0, 0, 0,             0, 0, 0});

    reset = 1'b1;
    fs_pc = '0;
    drive_upd(0, '0, 0, 0, '0, 0);

    // Reset sweep.
    @(negedge clk);
    for (int i = 0; i < 64; i++) begin
      fs_pc = 32'h8000_0000 | (32'(i) << 2);
      #1;
      chk_pred($sformatf("reset_idx%0d", i), 1'b0, 32'h0);
    end
    fs_pc = 32'hBFC0_0000; #1;
    chk_pred("reset_bfc", 1'b0, 32'h0);
    fs_pc = 32'h8000_0100; #1;
    chk_pred("reset_8100", 1'b0, 32'h0);
    chk("reset_perf_lk", perf_lookups, 32'h0);
    chk("reset_perf_mp", perf_mispredicts, 32'h0);

    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_pred("post_release", 1'b0, 32'h0);
    @(negedge clk);

    // Table-driven vectors.
    p0 = '0;
    foreach (vecs[k]) begin
      fs_pc = vecs[k].fs_pc;
      drive_upd(vecs[k].uv, vecs[k].upc, vecs[k].br, vecs[k].tk, vecs[k].tgt, vecs[k].mp);
      #2;
      if (k == 0) p0 = perf_lookups;
      chk_pred($sformatf("vec%0d", k), vecs[k].exp_t, vecs[k].exp_tgt);
      @(negedge clk);
    end
    drive_upd(0, '0, 0, 0, '0, 0);
    #1;
    chk("perf_mispredicts", perf_mispredicts, 32'd5);
    chk("perf_lookups_delta", perf_lookups - p0, 32'd25);

    // Mid-update reset: allocating update for PX is interrupted by reset and
    // held across the release edge; it must never land.
    fs_pc = PX;
    drive_upd(1, PX, 1, 1, 32'h8000_0300, 1);
    #2;
    reset = 1'b1;
    #1;
    chk_pred("midrst_pred", 1'b0, 32'h0);
    chk("midrst_perf_lk", perf_lookups, 32'h0);
    chk("midrst_perf_mp", perf_mispredicts, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_pred("midrst_release", 1'b0, 32'h0);
    @(negedge clk);
    drive_upd(0, '0, 0, 0, '0, 0);
    #1;
    chk_pred("midrst_not_alloc", 1'b0, 32'h0);
    chk("midrst_perf_lk1", perf_lookups, 32'd1);
    chk("midrst_perf_mp1", perf_mispredicts, 32'd0);
    fs_pc = PD;
    #1;
    chk_pred("midrst_cleared_pd", 1'b0, 32'h0);
    @(negedge clk);
    fs_pc = PX;
    #1;
    chk_pred("midrst_px_later", 1'b0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage dynamic branch predictor: direct-mapped branch target buffer with a 2-bit saturating direction counter per entry.
- Looked up each cycle with the PC of the instruction being fetched; supplies `predict_is_taken` / `predict_target`, which travel down the pipe to the EXE branch resolver.
- Trained by the resolved outcome that EXE sends back.
- Redirects fetch after the delay slot.
- Storage is flops, so reset invalidates every entry.

## Interface
Parameters:
- `ENTRIES`, 64: number of BTB entries; power of two, 4 to 256.
- `INDEX_W`, `$clog2(ENTRIES)`: index width; derived, not overridden.

Ports:
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset. One clock; reset is asynchronous and active-high.
- `fs_pc`  in  32  fetch PC (`virt_t`) to look up.
- `predict_is_taken`  out  1  predicted taken for `fs_pc`.
- `predict_target`  out  32  predicted target (`virt_t`); 0 when not taken.
- `upd_valid`  in  1  a resolved control-transfer report is present this cycle.
- `upd_pc`  in  32  PC of the resolved instruction (delay-slot PC − 4).
- `upd_is_branch`  in  1  the reported instruction is a branch or jump.
- `upd_taken`  in  1  resolved direction (`br_taken`).
- `upd_target`  in  32  resolved target (`br_target`).
- `upd_mispredict`  in  1  `!predict_sucess` for this report.
- `perf_lookups`  out  32  count of cycles with reset low.
- `perf_mispredicts`  out  32  count of `upd_valid && upd_mispredict`.

## Operation
- Index is `pc[INDEX_W+1:2]`.
- Tag is `pc[31:INDEX_W+2]`.
- Entry fields:
  - valid
  - tag
  - target[31:2]
  - 2-bit counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational):
  - Hit = valid && tag match.
  - `predict_is_taken` = hit && ctr[1].
  - `predict_target` = {target, 2'b00} when `predict_is_taken`, else 0.
- Update, on the rising edge when `upd_valid`:
  - Hit && `upd_is_branch`:
    - Counter increments when taken and decrements when not taken, saturating at 11 and 00.
    - When taken, target is overwritten with `upd_target[31:2]`.
  - Miss && `upd_is_branch` && `upd_taken`: allocate (overwrite the entry), with valid=1, tag, target, ctr=10.
  - Miss && not taken: no change.
  - Hit && !`upd_is_branch` (alias): clear valid.
  - `upd_valid`=0: no change, regardless of the other `upd_*` inputs.
- Perf counters wrap from 0xFFFF_FFFF to 0 and do not saturate.

## Timing
- Lookup latency: 0 cycles, combinational from `fs_pc` and current state.
- Update latency: written at the edge where `upd_valid`=1; visible to lookups from the next cycle.
- A lookup and an update to the same index in the same cycle: the lookup sees the pre-update state. There is no bypass.
- Reset, asserted at any time including mid-update:
  - All valid bits and counters clear immediately, asynchronously.
  - Both perf counters go to 0.
  - `predict_is_taken`=0 and `predict_target`=0 while reset is high and on the first cycle after release.
  - An update coinciding with the reset-release edge is dropped.
- There is no stall input. Lookup is stateless, so a repeated `fs_pc` yields the same prediction.

## Structure
- Shared package (`cpu_defs`):
  - `virt_t`
  - `bp_ctr_t` enum: SNT, WNT, WT, ST
  - `bp_entry_t` packed struct: valid, tag, target, ctr
- Tag width: `30-INDEX_W`, computed locally from the parameter.
- Sub-module `bp_sat_counter2`: combinational next-state of the 2-bit counter, with inputs ctr and taken. Instantiated once, in the update path.
- The table is an array of `bp_entry_t` registers with async reset. It is not an inferred RAM.

## Test plan
- **Reset sweep.** Reset, then look up 0xBFC0_0000, 0x8000_0100 and every index. Required: `predict_is_taken`=0 and `predict_target`=0 for every lookup.
- **Allocation and training.** Update pc=0x8000_0010 taken, target 0x8000_0080. Next-cycle lookup of 0x8000_0010 gives taken with target 0x8000_0080 (ctr=10). Two not-taken updates then give not taken (ctr=00). A third not-taken update leaves ctr at 00.
- **Saturation.** Four taken updates on one PC give ctr=11. One not-taken update gives ctr=10 and the prediction is still taken.
- **Aliasing and tag check.**
  - With ENTRIES=64, look up 0x8000_0110, which has the same index as 0x8000_0010 but a different tag. Required: not taken.
  - Update 0x8000_0010 with `upd_is_branch`=0. Required: the entry is invalidated.
- **Same-cycle update and lookup.** Lookup and allocating update on the same PC in one cycle. Required: the lookup returns not taken that cycle and taken in the following cycle.
- **Perf counters and mid-update reset.**
  - Five updates with `upd_mispredict`=1 give `perf_mispredicts`=5.
  - Assert reset mid-cycle during an update. Required: all outputs and counters are 0, and the entry is not allocated.
